// File: rtl/riscv_pkg.sv
// Shared definitions for the core's memory-side models.
`timescale 1ns/1ps
package riscv_pkg;

    localparam logic REQUEST   = 1'b1;
    localparam logic NOREQUEST = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        GNT_WAIT,
        BUSY,
        RESP
    } obi_mem_state_t;

endpackage

// File: rtl/obi_sram.sv
// Single-port DEPTH_WORDS x 32 word array, synchronous write, registered write-first read.
`timescale 1ns/1ps
module obi_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = ""
) (
    input  logic                           CLK,
    input  logic                           we,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write-first so a store that enters RESP on its own accept edge reads back its data.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= we ? wdata : mem[idx];
        end
    end

endmodule

// File: rtl/obi_data_mem.sv
// OBI-style data memory slave: one request at a time, programmable grant delay and response latency.
`timescale 1ns/1ps
module obi_data_mem
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int READY_DELAY = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        proc_req,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic        mem_rdy,
    output logic        valid,
    output logic [31:0] rdata
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int GNT_W = (READY_DELAY > 0) ? $clog2(READY_DELAY + 1) : 1;
    localparam int LAT_W = $clog2(LATENCY + 1);
    localparam logic [GNT_W-1:0] GNT_LAST = GNT_W'(READY_DELAY);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
    localparam obi_mem_state_t   ACCEPT_STATE = (LATENCY == 1) ? RESP : BUSY;

    obi_mem_state_t   state_reg, state_next;
    logic [GNT_W-1:0] gnt_cnt_reg, gnt_cnt_next;
    logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
    logic [IDX_W-1:0] idx_reg;
    logic             rdata_seen_reg;

    logic [IDX_W-1:0] addr_idx;
    logic [IDX_W-1:0] sram_idx;
    logic [31:0]      sram_rdata;
    logic             accept;
    logic             resp_entry;
    logic             unused_addr_bits;

    assign addr_idx         = addr[IDX_W+1:2];
    assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};
    assign accept           = (proc_req == REQUEST) && mem_rdy;
    assign resp_entry       = (state_next == RESP);
    // While BUSY the live address may churn, so the array is driven from the captured index.
    assign sram_idx         = (state_reg == BUSY) ? idx_reg : addr_idx;

    always_comb begin
        mem_rdy = 1'b0;
        case (state_reg)
            IDLE:     mem_rdy = (READY_DELAY == 0);
            GNT_WAIT: mem_rdy = (gnt_cnt_reg == GNT_LAST);
            default:  mem_rdy = 1'b0;
        endcase
    end

    assign valid = (state_reg == RESP);
    assign rdata = rdata_seen_reg ? sram_rdata : 32'h0;

    always_comb begin
        state_next   = state_reg;
        gnt_cnt_next = gnt_cnt_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (proc_req == REQUEST) begin
                    if (READY_DELAY == 0) begin
                        state_next   = ACCEPT_STATE;
                        lat_cnt_next = LAT_LOAD;
                    end else begin
                        state_next   = GNT_WAIT;
                        gnt_cnt_next = GNT_W'(1);
                    end
                end
            end
            GNT_WAIT: begin
                if (proc_req != REQUEST) begin
                    state_next   = IDLE;
                    gnt_cnt_next = '0;
                end else if (gnt_cnt_reg == GNT_LAST) begin
                    state_next   = ACCEPT_STATE;
                    gnt_cnt_next = '0;
                    lat_cnt_next = LAT_LOAD;
                end else begin
                    gnt_cnt_next = gnt_cnt_reg + GNT_W'(1);
                end
            end
            BUSY: begin
                if (lat_cnt_reg <= LAT_W'(1)) begin
                    state_next   = RESP;
                    lat_cnt_next = '0;
                end else begin
                    lat_cnt_next = lat_cnt_reg - LAT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg      <= IDLE;
            gnt_cnt_reg    <= '0;
            lat_cnt_reg    <= '0;
            idx_reg        <= '0;
            rdata_seen_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_cnt_reg <= gnt_cnt_next;
            lat_cnt_reg <= lat_cnt_next;
            if (accept) begin
                idx_reg <= addr_idx;
            end
            if (resp_entry) begin
                rdata_seen_reg <= 1'b1;
            end
        end
    end

    obi_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_sram (
        .CLK   (CLK),
        .we    (accept && we),
        .re    (resp_entry),
        .idx   (sram_idx),
        .wdata (wdata),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_obi_data_mem.sv
// Directed bench: d0 is LATENCY=2/READY_DELAY=0, d1 is LATENCY=1/READY_DELAY=3, both 16 words deep.
`timescale 1ns/1ps
module tb_obi_data_mem;
    import riscv_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        req0, we0, rdy0, valid0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, rdy1, valid1;
    logic [31:0] addr1, wdata1, rdata1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    obi_data_mem #(.DEPTH_WORDS(16), .LATENCY(2), .READY_DELAY(0), .INIT_FILE("")) d0 (
        .CLK(CLK), .RSTn(RSTn), .proc_req(req0), .addr(addr0), .we(we0), .wdata(wdata0),
        .mem_rdy(rdy0), .valid(valid0), .rdata(rdata0)
    );

    obi_data_mem #(.DEPTH_WORDS(16), .LATENCY(1), .READY_DELAY(3), .INIT_FILE("")) d1 (
        .CLK(CLK), .RSTn(RSTn), .proc_req(req1), .addr(addr1), .we(we1), .wdata(wdata1),
        .mem_rdy(rdy1), .valid(valid1), .rdata(rdata1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered at the falling edge of the accept cycle k; returns at the falling edge of k+3.
    task automatic d0_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input bit hold_req);
        req0 = REQUEST; we0 = w; addr0 = a; wdata0 = d;
        check_eq("d0 rdy at accept", rdy0, 32'd1);
        @(negedge CLK);
        req0 = hold_req ? REQUEST : NOREQUEST;
        we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hFFFF_FFFF;
        check_eq("d0 valid k+1", valid0, 32'd0);
        check_eq("d0 rdy k+1", rdy0, 32'd0);
        @(negedge CLK);
        addr0 = 32'h14; wdata0 = 32'hEEEE_EEEE;
        check_eq("d0 valid k+2", valid0, 32'd1);
        check_eq("d0 rdy k+2", rdy0, 32'd0);
        check_eq("d0 rdata k+2", rdata0, exp);
        @(negedge CLK);
        req0 = NOREQUEST; we0 = 1'b0;
        check_eq("d0 valid k+3", valid0, 32'd0);
        check_eq("d0 rdy k+3", rdy0, 32'd1);
        check_eq("d0 rdata held", rdata0, exp);
        $display("d0 %s addr=0x%08h wdata=0x%08h rdata=0x%08h expect=0x%08h",
                 w ? "WR" : "RD", a, d, rdata0, exp);
    endtask

    initial begin
        RSTn = 1'b0;
        req0 = NOREQUEST; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = NOREQUEST; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(negedge CLK);
        check_eq("reset d0 valid", valid0, 32'd0);
        check_eq("reset d0 rdata", rdata0, 32'd0);
        check_eq("reset d0 rdy", rdy0, 32'd1);
        check_eq("reset d1 rdy", rdy1, 32'd0);
        check_eq("reset d1 valid", valid1, 32'd0);
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_eq("idle d0 valid", valid0, 32'd0);
            check_eq("idle d0 rdy", rdy0, 32'd1);
            check_eq("idle d0 rdata", rdata0, 32'd0);
        end
        $display("reset and idle done");

        d0_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        d0_xfer(1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);
        d0_xfer(1'b1, 32'h43, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0);
        d0_xfer(1'b1, 32'h04, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        d0_xfer(1'b0, 32'h40, 32'h0,         32'h5A5A_5A5A, 1'b0);
        d0_xfer(1'b0, 32'h80, 32'h0,         32'h5A5A_5A5A, 1'b0);
        d0_xfer(1'b0, 32'h04, 32'h0,         32'h0BAD_F00D, 1'b0);
        d0_xfer(1'b0, 32'h00, 32'h0,         32'h5A5A_5A5A, 1'b0);
        // Request held high through BUSY/RESP with churning write inputs aimed at 0x10/0x14.
        d0_xfer(1'b1, 32'h08, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
        d0_xfer(1'b0, 32'h08, 32'h0,         32'hCAFE_F00D, 1'b0);
        d0_xfer(1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);

        // Reset while the write to 0x20 sits in BUSY.
        req0 = REQUEST; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
        check_eq("midrst rdy at accept", rdy0, 32'd1);
        @(negedge CLK);
        req0 = NOREQUEST; we0 = 1'b0;
        RSTn = 1'b0;
        #1;
        check_eq("midrst valid", valid0, 32'd0);
        check_eq("midrst rdata", rdata0, 32'd0);
        @(negedge CLK);
        check_eq("midrst valid later", valid0, 32'd0);
        check_eq("midrst rdy", rdy0, 32'd1);
        RSTn = 1'b1;
        @(negedge CLK);
        check_eq("post rst valid", valid0, 32'd0);
        $display("d0 reset mid-write addr=0x00000020");
        d0_xfer(1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);

        // d1: grant after three cycles of held request, single-cycle latency.
        req1 = REQUEST; we1 = 1'b1; addr1 = 32'h0C; wdata1 = 32'h1111_2222;
        check_eq("d1 rdy c0", rdy1, 32'd0);
        for (int c = 1; c < 3; c++) begin
            @(negedge CLK);
            check_eq("d1 rdy delay", rdy1, 32'd0);
        end
        @(negedge CLK);
        check_eq("d1 rdy c3", rdy1, 32'd1);
        @(negedge CLK);
        req1 = NOREQUEST; we1 = 1'b0;
        check_eq("d1 valid wr", valid1, 32'd1);
        check_eq("d1 rdata wr", rdata1, 32'h1111_2222);
        check_eq("d1 rdy in resp", rdy1, 32'd0);
        @(negedge CLK);
        check_eq("d1 valid after", valid1, 32'd0);
        check_eq("d1 rdy idle", rdy1, 32'd0);
        $display("d1 WR addr=0x0000000c wdata=0x11112222 rdata=0x%08h", rdata1);

        // Drop the request in cycle 2; the count must restart from scratch.
        req1 = REQUEST; we1 = 1'b0; addr1 = 32'h0C;
        @(negedge CLK);
        check_eq("d1 drop c1", rdy1, 32'd0);
        @(negedge CLK);
        req1 = NOREQUEST;
        check_eq("d1 drop c2", rdy1, 32'd0);
        @(negedge CLK);
        check_eq("d1 drop c3", rdy1, 32'd0);
        req1 = REQUEST;
        for (int c = 4; c < 6; c++) begin
            @(negedge CLK);
            check_eq("d1 restart delay", rdy1, 32'd0);
        end
        @(negedge CLK);
        check_eq("d1 restart grant", rdy1, 32'd1);
        @(negedge CLK);
        req1 = NOREQUEST;
        check_eq("d1 valid rd", valid1, 32'd1);
        check_eq("d1 rdata rd", rdata1, 32'h1111_2222);
        $display("d1 RD addr=0x0000000c rdata=0x%08h", rdata1);
        @(negedge CLK);
        check_eq("d1 valid end", valid1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
